// File: rtl/npc_pipe_pkg.sv
// npc_pipe_pkg: shared definitions for NPC pipeline-stage registers.
//   - stage_state_e : fill state of a pipe_stage_reg (EMPTY / ONE / TWO)
//   - OCC_*         : occupancy encodings reported on the occupancy port
//   - *_W           : default payload widths per pipeline boundary
//   - occ_of_state  : maps a fill state to its occupancy encoding
package npc_pipe_pkg;

  localparam int unsigned OCC_W = 2;

  localparam logic [OCC_W-1:0] OCC_EMPTY = 2'd0;
  localparam logic [OCC_W-1:0] OCC_ONE   = 2'd1;
  localparam logic [OCC_W-1:0] OCC_TWO   = 2'd2;

  // Default stage widths per pipeline boundary
  localparam int unsigned IF_ID_W  = 62;
  localparam int unsigned ID_EX_W  = 62;
  localparam int unsigned EX_MEM_W = 62;
  localparam int unsigned MEM_WB_W = 62;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  // Occupancy reported for a given fill state
  function automatic logic [OCC_W-1:0] occ_of_state(input stage_state_e st);
    logic [OCC_W-1:0] occ;
    occ = OCC_EMPTY;
    case (st)
      ST_EMPTY: occ = OCC_EMPTY;
      ST_ONE:   occ = OCC_ONE;
      ST_TWO:   occ = OCC_TWO;
      default:  occ = OCC_EMPTY;
    endcase
    return occ;
  endfunction

endpackage : npc_pipe_pkg

// File: rtl/pipe_data_reg.sv
// pipe_data_reg: enable register with synchronous active-low reset.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset, loads RST_VAL
//   en    : load d on the next rising edge
//   d     : WIDTH-bit data in
//   q     : WIDTH-bit registered data out
module pipe_data_reg #(
  parameter int unsigned       WIDTH   = 62,
  parameter logic [WIDTH-1:0]  RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Hold unless enabled; reset wins over enable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : pipe_data_reg

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one-cycle pipeline-stage register with valid/ready
// handshake, synchronous flush and optional two-entry skid buffer.
//   clk, rst_n          : clock (rising edge), synchronous active-low reset
//   in_valid/in_ready   : upstream handshake, in_data payload
//   out_valid/out_ready : downstream handshake, out_data payload
//   flush               : squash all held entries (an out_xfer still completes)
//   occupancy           : entries held, 0..2
// Build option: define PIPE_STAGE_REG_SKID_EN for the two-entry skid buffer
// with fully registered in_ready. Without it the stage holds a single entry
// and in_ready = out_ready || !out_valid (combinational from out_ready).
module pipe_stage_reg
  import npc_pipe_pkg::*;
#(
  parameter int unsigned       WIDTH   = 62,
  parameter logic [WIDTH-1:0]  RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy
);

  stage_state_e     state_q;
  stage_state_e     state_d;
  logic             main_valid_q;
  logic             main_en;
  logic [WIDTH-1:0] main_d;
  logic             in_xfer;
  logic             out_xfer;

  assign out_valid = main_valid_q;
  assign out_xfer  = main_valid_q & out_ready;
  assign in_xfer   = in_valid & in_ready;

`ifdef PIPE_STAGE_REG_SKID_EN

  logic             skid_valid_q;
  logic             in_ready_q;
  logic [1:0]       occ_q;
  logic             skid_en;
  logic             main_sel_skid;
  logic [WIDTH-1:0] skid_q;

  // Registered: no path from out_ready to in_ready
  assign in_ready  = in_ready_q;
  assign occupancy = occ_q;
  assign main_d    = main_sel_skid ? skid_q : in_data;

  // Next state and data-register enables; flush suppresses all data writes
  always_comb begin
    state_d       = state_q;
    main_en       = 1'b0;
    skid_en       = 1'b0;
    main_sel_skid = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d = ST_ONE;
            main_en = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_en = 1'b1;
          end else if (in_xfer) begin
            state_d = ST_TWO;
            skid_en = 1'b1;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the drain transition exists
          if (out_xfer) begin
            state_d       = ST_ONE;
            main_en       = 1'b1;
            main_sel_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State and registered status outputs, all derived from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      occ_q        <= OCC_EMPTY;
    end else begin
      state_q      <= state_d;
      main_valid_q <= (state_d != ST_EMPTY);
      skid_valid_q <= (state_d == ST_TWO);
      in_ready_q   <= (state_d != ST_TWO);
      occ_q        <= occ_of_state(state_d);
    end
  end

  pipe_data_reg #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_skid_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_q)
  );

`else

  // Single entry: accept whenever the held beat leaves this cycle
  assign in_ready  = out_ready | ~main_valid_q;
  assign occupancy = {1'b0, main_valid_q};
  assign main_d    = in_data;

  // Next state and main-register enable; flush suppresses data writes
  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d = ST_ONE;
            main_en = 1'b1;
          end
        end
        ST_ONE: begin
          // in_xfer here implies out_xfer, since in_ready needs out_ready
          if (in_xfer) begin
            main_en = 1'b1;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State and registered valid bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      main_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      main_valid_q <= (state_d != ST_EMPTY);
    end
  end

`endif

  pipe_data_reg #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_main_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (main_en),
    .d     (main_d),
    .q     (out_data)
  );

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed plus random stimulus against a FIFO-queue
// reference model of the stage (capacity 2 with skid buffer, else 1).
module tb_pipe_stage_reg;

  localparam int unsigned W = 62;
  localparam logic [W-1:0] RST_V = '0;
`ifdef PIPE_STAGE_REG_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         flush;
  logic [1:0]   occupancy;

  int checks = 0;
  int failures = 0;

  // Reference model: queue of held beats plus last value left on out_data
  logic [W-1:0] mq[$];
  logic [W-1:0] held;
  bit           known = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(W), .RST_VAL(RST_V)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .occupancy (occupancy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, compare against the model, then advance it
  task automatic step(input logic rn, input logic iv, input logic [W-1:0] id,
                      input logic ordy, input logic fl);
    bit           exp_ir;
    bit           exp_ov;
    bit           ix;
    bit           ox;
    logic [W-1:0] exp_od;
    logic [W-1:0] held_pre;
    @(negedge clk);
    rst_n = rn; in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
    #1;
    exp_ir = SKID ? (mq.size() < 2) : (mq.size() == 0 || ordy);
    exp_ov = (mq.size() > 0);
    exp_od = exp_ov ? mq[0] : held;
    if (known) begin
      check("in_ready",  64'(in_ready),  64'(exp_ir));
      check("out_valid", 64'(out_valid), 64'(exp_ov));
      check("occupancy", 64'(occupancy), 64'(mq.size()));
      check("out_data",  64'(out_data),  64'(exp_od));
    end
    @(posedge clk);
    if (!rn) begin
      mq.delete();
      held  = RST_V;
      known = 1'b1;
    end else if (known) begin
      ix = iv && exp_ir;
      ox = exp_ov && ordy;
      held_pre = exp_od;
      if (ox) void'(mq.pop_front());
      if (fl) begin
        mq.delete();
        held = held_pre;
      end else begin
        if (ix) mq.push_back(id);
        held = (mq.size() > 0) ? mq[0] : held_pre;
      end
    end
  endtask

  initial begin
    logic [W-1:0] rd;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;

    // Reset held for two cycles with a live input
    step(1'b0, 1'b1, W'(1), 1'b0, 1'b0);
    step(1'b0, 1'b1, W'(1), 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    check("rst_out_data", 64'(out_data), 64'(RST_V));

    // Streaming
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, W'(32'h10 + i), 1'b1, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);

    // Back-pressure then release
    step(1'b1, 1'b1, W'(32'hA0), 1'b0, 1'b0);
    step(1'b1, 1'b1, W'(32'hA1), 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b1, 1'b0);

    // Flush while full with a live input beat
    step(1'b1, 1'b1, W'(32'hB0), 1'b0, 1'b0);
    step(1'b1, 1'b1, W'(32'hB1), 1'b0, 1'b0);
    step(1'b1, 1'b1, W'(32'hFF), 1'b0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);

    // Flush coinciding with an output transfer
    step(1'b1, 1'b1, W'(32'hC0), 1'b0, 1'b0);
    step(1'b1, 1'b1, W'(32'hC1), 1'b1, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rd = W'({$urandom(), $urandom()});
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 3) != 0),
           rd,
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 15) == 0));
    end
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pipe_stage_reg
